// File: rtl/streambuf_in_ctrl_if.sv
// Buffer read port plus decoder-side stream handshake for the input stream buffer controller.
interface streambuf_in_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output mem_addr, mem_rd_en, out_data, out_valid, out_last,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, out_data, out_valid, out_last,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/streambuf_in_ctrl.sv
// Streams whole codeword frames from the input buffer to the decoder front end,
// one word per read/load/transfer cycle triple, with last-word flagging and abort.
module streambuf_in_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int FRAME_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] num_frames,
  input  logic                  abort,
  streambuf_in_ctrl_if.master   bus,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] frame_cnt
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [FRAME_BITS-1:0] FRAME_ONE = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LD   = 3'd2,
    XFER = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state;
  logic [FRAME_BITS-1:0] nf_lat;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  last;
  logic [FRAME_BITS-1:0] frame_inc;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  at_max;

  assign bus.mem_addr  = addr;
  assign bus.mem_rd_en = rd_en;
  assign bus.out_data  = data;
  assign bus.out_valid = valid;
  assign bus.out_last  = last;

  always_comb begin
    frame_inc = frame_cnt + FRAME_ONE;
    addr_inc  = addr + ADDR_ONE;
    at_max    = (addr == ADDR_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      nf_lat    <= '0;
      addr      <= '0;
      rd_en     <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && (num_frames != '0)) begin
            nf_lat    <= num_frames;
            frame_cnt <= '0;
            addr      <= '0;
            rd_en     <= 1'b1;
            busy      <= 1'b1;
            state     <= RD;
          end
        end

        RD: begin
          rd_en <= 1'b0;
          if (abort) begin
            addr  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= LD;
          end
        end

        // Read data arrives this cycle; present it to the decoder next cycle.
        LD: begin
          if (abort) begin
            addr  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            data  <= bus.mem_rd_data;
            valid <= 1'b1;
            last  <= at_max;
            state <= XFER;
          end
        end

        XFER: begin
          if (bus.out_ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
            if (at_max) begin
              addr      <= '0;
              frame_cnt <= frame_inc;
              if (abort) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else if (frame_inc == nf_lat) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                rd_en <= 1'b1;
                state <= RD;
              end
            end else if (abort) begin
              // Word was accepted, but the transfer ends here.
              addr  <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              addr  <= addr_inc;
              rd_en <= 1'b1;
              state <= RD;
            end
          end else if (abort) begin
            valid <= 1'b0;
            last  <= 1'b0;
            addr  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          rd_en <= 1'b0;
          valid <= 1'b0;
          last  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_streambuf_in_ctrl.sv
// Directed bench for streambuf_in_ctrl: scoreboard of expected words checked by a handshake monitor.
module tb_streambuf_in_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] num_frames;
  logic       abort;
  logic       busy;
  logic       done;
  logic [3:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mem [4];

  streambuf_in_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) bus ();

  streambuf_in_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .FRAME_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_frames (num_frames),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous buffer memory: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_word", {15'd0, bus.out_last, bus.out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("word_data", {16'd0, bus.out_data}, {16'd0, e.data});
        chk("word_last", {31'd0, bus.out_last}, {31'd0, e.last});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int a = 0; a < 4; a++) begin
        exp_t e;
        e.data = mem[a];
        e.last = (a == 3);
        q.push_back(e);
      end
  endtask

  // Pulses start for one edge; returns in the first cycle after the sampling edge.
  task automatic start_xfer(input logic [3:0] n);
    start = 1'b1;
    num_frames = n;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (done === 1'b1) found = 1;
      else step();
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_fc;
    int done_cnt;
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003; mem[3] = 16'h0004;
    rst = 1'b0; start = 1'b0; num_frames = '0; abort = 1'b0; bus.out_ready = 1'b1;
    bus.mem_rd_data = '0;
    repeat (3) step();

    chk("rst_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_rden", {31'd0, bus.mem_rd_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_addr", {30'd0, bus.mem_addr}, 0);
    chk("rst_data", {16'd0, bus.out_data}, 0);
    chk("rst_fcnt", {28'd0, frame_cnt}, 0);
    rst = 1'b1;
    step();

    // 1: single frame, exact cycle latencies
    push_frames(1);
    start_xfer(4'd1);
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("t1_valid_c%0d", k), {31'd0, bus.out_valid}, {31'd0, (k % 3 == 0) && (k <= 12)});
      chk($sformatf("t1_rden_c%0d", k), {31'd0, bus.mem_rd_en}, {31'd0, (k % 3 == 1) && (k <= 10)});
      chk($sformatf("t1_done_c%0d", k), {31'd0, done}, {31'd0, k == 13});
      chk($sformatf("t1_busy_c%0d", k), {31'd0, busy}, {31'd0, k <= 12});
      step();
    end
    chk("t1_fcnt", {28'd0, frame_cnt}, 1);
    chk("t1_queue", q.size(), 0);

    // 2: three frames back to back
    push_frames(3);
    start_xfer(4'd3);
    prev_fc = 0;
    done_cnt = 0;
    for (int k = 0; k < 45; k++) begin
      if (int'(frame_cnt) != prev_fc) begin
        chk("t2_fcnt_step", {28'd0, frame_cnt}, prev_fc + 1);
        prev_fc = int'(frame_cnt);
      end
      if (done === 1'b1) done_cnt++;
      step();
    end
    chk("t2_fcnt", {28'd0, frame_cnt}, 3);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_addr", {30'd0, bus.mem_addr}, 0);
    chk("t2_queue", q.size(), 0);

    // 3: backpressure on word 2
    push_frames(1);
    start_xfer(4'd1);
    repeat (4) step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_hold_valid", {31'd0, bus.out_valid}, 1);
      chk("t3_hold_data", {16'd0, bus.out_data}, 32'h0002);
      chk("t3_hold_rden", {31'd0, bus.mem_rd_en}, 0);
    end
    bus.out_ready = 1'b1;
    wait_done("t3_done", 40);
    step();
    chk("t3_queue", q.size(), 0);

    // 4: abort in LD of word 3, frame 2
    for (int a = 0; a < 6; a++) begin
      exp_t e;
      e.data = mem[a % 4];
      e.last = (a == 3);
      q.push_back(e);
    end
    start_xfer(4'd2);
    repeat (19) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_valid", {31'd0, bus.out_valid}, 0);
    chk("t4_busy", {31'd0, busy}, 0);
    chk("t4_addr", {30'd0, bus.mem_addr}, 0);
    chk("t4_fcnt", {28'd0, frame_cnt}, 1);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1 || bus.mem_rd_en === 1'b1) done_cnt++;
      step();
    end
    chk("t4_quiet", done_cnt, 0);
    chk("t4_queue", q.size(), 0);
    push_frames(1);
    start_xfer(4'd1);
    chk("t4_restart_addr", {30'd0, bus.mem_addr}, 0);
    wait_done("t4_done", 40);
    step();

    // 5: zero-frame start, then start while busy
    start_xfer(4'd0);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1 || bus.mem_rd_en === 1'b1 || busy === 1'b1) done_cnt++;
      step();
    end
    chk("t5_zero_quiet", done_cnt, 0);
    push_frames(1);
    start_xfer(4'd1);
    start = 1'b1;
    num_frames = 4'd5;
    step();
    start = 1'b0;
    wait_done("t5_done", 40);
    chk("t5_fcnt", {28'd0, frame_cnt}, 1);
    step();
    repeat (4) step();
    chk("t5_idle_busy", {31'd0, busy}, 0);
    chk("t5_queue", q.size(), 0);

    // 6: reset mid-frame, then reset together with start
    push_frames(1);
    start_xfer(4'd2);
    repeat (12) step();
    bus.out_ready = 1'b0;
    repeat (2) step();
    chk("t6_pre_valid", {31'd0, bus.out_valid}, 1);
    chk("t6_pre_data", {16'd0, bus.out_data}, 32'h0001);
    chk("t6_pre_fcnt", {28'd0, frame_cnt}, 1);
    rst = 1'b0;
    step();
    chk("t6_valid", {31'd0, bus.out_valid}, 0);
    chk("t6_last", {31'd0, bus.out_last}, 0);
    chk("t6_rden", {31'd0, bus.mem_rd_en}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_done", {31'd0, done}, 0);
    chk("t6_data", {16'd0, bus.out_data}, 0);
    chk("t6_fcnt", {28'd0, frame_cnt}, 0);
    chk("t6_addr", {30'd0, bus.mem_addr}, 0);
    start_xfer(4'd3);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("t6_rst_start_rden", {31'd0, bus.mem_rd_en}, 0);
    chk("t6_rst_start_busy", {31'd0, busy}, 0);
    chk("t6_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
